fifo_enq_arbiter: RTL
=====================

Name: fifo_enq_arbiter

Overview:
- Controller in front of the 8-entry, 4-bit `fifo`. It shares the FIFO's single enqueue port between two producers (req0/data0, req1/data1) and sequences dequeues from one consumer.
- Producer and consumer inputs are held levels, as from buttons or switches. The block edge-detects them, arbitrates round-robin, and issues single-cycle enq/deq pulses to the FIFO.
- It honours full/empty and leaves one settle cycle after each FIFO operation.

Parameters:
- WIDTH, 4: data width of data0, data1 and fifo_in.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  producer 0 request level; each rising edge is one enqueue request.
- data0  in  WIDTH  producer 0 data, sampled on the cycle req0's edge is detected.
- req1  in  1  producer 1 request level.
- data1  in  WIDTH  producer 1 data, sampled on edge detect.
- deq_req  in  1  consumer request level; each rising edge is one dequeue request.
- full  in  1  from fifo.
- empty  in  1  from fifo.
- enq  out  1  one-cycle enqueue strobe to fifo.
- deq  out  1  one-cycle dequeue strobe to fifo.
- fifo_in  out  WIDTH  data presented with enq.
- grant0  out  1  one-cycle pulse: producer 0 request written.
- grant1  out  1  one-cycle pulse: producer 1 request written.
- drop  out  2  one-cycle pulse per bit: request of producer i discarded because FIFO was full.
- deq_nack  out  1  one-cycle pulse: dequeue request discarded because FIFO was empty.

Behaviour:
- Reset:
  - enq, deq, grant0/1, drop and deq_nack are 0; fifo_in is 0.
  - Pending flags are cleared, state is IDLE and the round-robin pointer is set to 0 (producer 0 has priority first).
  - Edge registers load the current req0/req1/deq_req, so a level held through reset produces no request.
- Edge detect:
  - pendN <= 1 on (reqN & ~prevN), and dataN is latched into holdN the same cycle.
  - A new edge while pendN is already 1 is ignored; the first held data wins.
  - pend_d is set the same way from deq_req.
- FSM states: IDLE, ENQ, DEQ, SETTLE.
- IDLE, priority order:
  1. pend_d: go to DEQ.
  2. Else any pendN: pick producer N by round-robin. The pointer names the preferred producer. If only one is pending it is picked regardless of the pointer. Then go to ENQ.
- DEQ (one cycle):
  - If ~empty: deq=1.
  - Else: deq_nack=1.
  - pend_d is cleared; go to SETTLE.
- ENQ (one cycle):
  - If ~full: enq=1, fifo_in=holdN, grantN=1.
  - Else: drop[N]=1, no enq.
  - pendN is cleared; the pointer is set to ~N; go to SETTLE.
- SETTLE (one cycle): no strobes; go to IDLE. This lets full/empty reflect the last operation.
- Latency:
  - Uncontested request: edge detected in cycle t, IDLE decides in t+1, strobe in t+2.
  - Minimum spacing between strobes is 3 cycles (op, SETTLE, IDLE).
- Strobe rules:
  - enq and deq are never asserted in the same cycle.
  - Each strobe is exactly one cycle, however long the input is held.
- Simultaneous edges on all three inputs: served in the order deq, then preferred producer, then the other producer. No request is lost unless it hits full/empty.
- Edges arriving during ENQ/DEQ/SETTLE are latched and served later. An edge arriving in the same cycle its pending flag is being cleared re-sets the flag; the set wins.
- fifo_in holds its last driven value when enq=0.
- Reset asserted mid-operation: returns to reset values the next cycle. No strobe is issued in the reset cycle.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined: adds outputs gcnt0, gcnt1, dcnt (8 bits each). They count grant0, grant1 and drop pulses (either bit of drop).
  - Counters wrap modulo 256 and clear on rst.
- Undefined: these ports and counters are absent; everything else is identical.

Decomposition:
- Package fifo_arb_pkg:
  - State encoding localparams S_IDLE=2'd0, S_ENQ=2'd1, S_DEQ=2'd2, S_SETTLE=2'd3.
  - Default WIDTH=4.
- Sub-module edge_latch (instantiated three times): edge detect, pending flag and optional data hold.
  - Ports: clk, rst, lvl, din, clr → pend, dout.

Test Plan:
- Reset with req0 held high, then release rst → no pend, no enq. Drop req0, then raise it with data0=6 → enq=1 with fifo_in=6 and grant0=1 exactly two cycles after the edge; only one pulse while req0 is held for 5 cycles.
- req0 (data0=9) and req1 (data1=7) rise in the same cycle, pointer=0 → enq 9 (grant0), SETTLE, IDLE, enq 7 (grant1), three cycles apart. Repeat both → order is 7 first only if the pointer ended at 1; check that the pointer alternates.
- Fill the FIFO with 8 enqueues of 7,5,3,4,a,3,2,b, then raise req1 with data1=c while full=1 → drop[1]=1, enq stays 0, grant1=0. With FIFO_ARB_STATS_EN, dcnt=1 and gcnt totals 8.
- deq_req edge while empty=1 → deq_nack=1, deq=0. After one enqueue, a deq_req edge → deq=1 for one cycle.
- Edges on deq_req, req0 and req1 in the same cycle → deq first, then producer 0, then producer 1. Strobes are never coincident and are spaced exactly 3 cycles.
- Assert rst during ENQ → no enq the next cycle; all outputs at reset values; pending requests gone. A fresh req1 edge is then served normally.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and state type for the FIFO enqueue arbiter.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned STAT_W        = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENQ    = 2'd1;
  localparam logic [1:0] S_DEQ    = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ENQ    = S_ENQ,
    ST_DEQ    = S_DEQ,
    ST_SETTLE = S_SETTLE
  } arb_state_e;

endpackage

// File: rtl/fifo_enq_arbiter_edge_latch.sv
// Rising-edge detector with a sticky pending flag and first-edge data capture.
module edge_latch
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lvl,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic             pend,
  output logic [WIDTH-1:0] dout
);

  logic             r_prev;
  logic             r_pend;
  logic [WIDTH-1:0] r_hold;
  logic             w_rise;

  assign w_rise = lvl & ~r_prev;

  // A fresh edge in the clearing cycle re-arms the flag with new data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= lvl;
      r_pend <= 1'b0;
      r_hold <= '0;
    end else begin
      r_prev <= lvl;
      if (w_rise && (!r_pend || clr)) begin
        r_pend <= 1'b1;
        r_hold <= din;
      end else if (clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign pend = r_pend;
  assign dout = r_hold;

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port between two producers plus a dequeuer.
// Define FIFO_ARB_STATS_EN to add grant/drop counters (gcnt0, gcnt1, dcnt).
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             deq_req,
  input  logic             full,
  input  logic             empty,
  output logic             enq,
  output logic             deq,
  output logic [WIDTH-1:0] fifo_in,
  output logic             grant0,
  output logic             grant1,
  output logic [1:0]       drop,
  output logic             deq_nack
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gcnt0,
  output logic [STAT_W-1:0] gcnt1,
  output logic [STAT_W-1:0] dcnt
`endif
);

  logic             w_pend0, w_pend1, w_pend_d;
  logic [WIDTH-1:0] w_hold0, w_hold1;
  logic             w_unused_dq;
  logic             w_clr0, w_clr1, w_clr_d;

  arb_state_e       r_state, w_nxt_state;
  logic             r_ptr, w_nxt_ptr;
  logic             r_sel, w_nxt_sel;
  logic             r_enq, w_nxt_enq;
  logic             r_deq, w_nxt_deq;
  logic [WIDTH-1:0] r_fifo_in, w_nxt_fifo_in;
  logic             r_grant0, w_nxt_grant0;
  logic             r_grant1, w_nxt_grant1;
  logic [1:0]       r_drop, w_nxt_drop;
  logic             r_deq_nack, w_nxt_deq_nack;

  edge_latch #(.WIDTH(WIDTH)) u_lat0 (
    .clk(clk), .rst(rst), .lvl(req0), .din(data0), .clr(w_clr0),
    .pend(w_pend0), .dout(w_hold0)
  );

  edge_latch #(.WIDTH(WIDTH)) u_lat1 (
    .clk(clk), .rst(rst), .lvl(req1), .din(data1), .clr(w_clr1),
    .pend(w_pend1), .dout(w_hold1)
  );

  edge_latch #(.WIDTH(1)) u_latd (
    .clk(clk), .rst(rst), .lvl(deq_req), .din(1'b0), .clr(w_clr_d),
    .pend(w_pend_d), .dout(w_unused_dq)
  );

  // Decisions are made in IDLE so the strobe registers are loaded on entry to ENQ/DEQ
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ptr      = r_ptr;
    w_nxt_sel      = r_sel;
    w_nxt_enq      = 1'b0;
    w_nxt_deq      = 1'b0;
    w_nxt_fifo_in  = r_fifo_in;
    w_nxt_grant0   = 1'b0;
    w_nxt_grant1   = 1'b0;
    w_nxt_drop     = 2'b00;
    w_nxt_deq_nack = 1'b0;
    w_clr0         = 1'b0;
    w_clr1         = 1'b0;
    w_clr_d        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_d) begin
          w_nxt_state    = ST_DEQ;
          w_nxt_deq      = ~empty;
          w_nxt_deq_nack = empty;
        end else if (w_pend0 || w_pend1) begin
          w_nxt_state = ST_ENQ;
          w_nxt_sel   = (w_pend0 && w_pend1) ? r_ptr : w_pend1;
          if (!full) begin
            w_nxt_enq     = 1'b1;
            w_nxt_fifo_in = w_nxt_sel ? w_hold1 : w_hold0;
            w_nxt_grant0  = ~w_nxt_sel;
            w_nxt_grant1  = w_nxt_sel;
          end else begin
            w_nxt_drop = w_nxt_sel ? 2'b10 : 2'b01;
          end
        end
      end
      ST_ENQ: begin
        w_clr0      = ~r_sel;
        w_clr1      = r_sel;
        w_nxt_ptr   = ~r_sel;
        w_nxt_state = ST_SETTLE;
      end
      ST_DEQ: begin
        w_clr_d     = 1'b1;
        w_nxt_state = ST_SETTLE;
      end
      ST_SETTLE: w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_sel      <= 1'b0;
      r_enq      <= 1'b0;
      r_deq      <= 1'b0;
      r_fifo_in  <= '0;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_drop     <= 2'b00;
      r_deq_nack <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_ptr      <= w_nxt_ptr;
      r_sel      <= w_nxt_sel;
      r_enq      <= w_nxt_enq;
      r_deq      <= w_nxt_deq;
      r_fifo_in  <= w_nxt_fifo_in;
      r_grant0   <= w_nxt_grant0;
      r_grant1   <= w_nxt_grant1;
      r_drop     <= w_nxt_drop;
      r_deq_nack <= w_nxt_deq_nack;
    end
  end

  assign enq      = r_enq;
  assign deq      = r_deq;
  assign fifo_in  = r_fifo_in;
  assign grant0   = r_grant0;
  assign grant1   = r_grant1;
  assign drop     = r_drop;
  assign deq_nack = r_deq_nack;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_gcnt0, r_gcnt1, r_dcnt;

  // Counters advance on the same edge that loads the matching pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
      r_dcnt  <= '0;
    end else begin
      r_gcnt0 <= r_gcnt0 + STAT_W'(w_nxt_grant0);
      r_gcnt1 <= r_gcnt1 + STAT_W'(w_nxt_grant1);
      r_dcnt  <= r_dcnt + STAT_W'(|w_nxt_drop);
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
  assign dcnt  = r_dcnt;
`endif

endmodule
